// File: rtl/acs_unit.sv
// Add-compare-select node for one state of a 64-state hard-decision Viterbi decoder.
// Keeps the state's path metric, emits a survivor bit per step and supports global normalisation.
module acs_unit #(
  parameter int unsigned PM_W     = 8,
  parameter int unsigned STATE_ID = 0,
  parameter int unsigned INIT_MAX = 63,
  parameter int unsigned NORM_SUB = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            step_valid,
  input  logic [PM_W-1:0] pm_in_0,
  input  logic [PM_W-1:0] pm_in_1,
  input  logic [1:0]      bm_0,
  input  logic [1:0]      bm_1,
  input  logic            norm_en,
  output logic [PM_W-1:0] pm_out,
  output logic            dec_bit,
  output logic            dec_valid,
  output logic            norm_req,
  output logic            busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [PM_W-1:0] INIT_PM = (STATE_ID == 0) ? '0 : PM_W'(INIT_MAX);
  localparam logic [PM_W:0]   SUB_W   = (PM_W+1)'(NORM_SUB);
  localparam logic [PM_W:0]   MAX_W   = {1'b0, {PM_W{1'b1}}};

  state_t          state;
  logic [PM_W:0]   s0, s1, win, pm_ext;
  logic            sel;
  logic [PM_W-1:0] acs_pm, norm_pm;

  // Normalisation is applied before saturation so a large sum can still land in range.
  always_comb begin
    s0     = {1'b0, pm_in_0} + (PM_W+1)'(bm_0);
    s1     = {1'b0, pm_in_1} + (PM_W+1)'(bm_1);
    sel    = (s1 < s0);
    win    = sel ? s1 : s0;
    if (norm_en)
      win = (win < SUB_W) ? '0 : win - SUB_W;
    acs_pm = (win > MAX_W) ? '1 : win[PM_W-1:0];
    pm_ext  = {1'b0, pm_out};
    norm_pm = (pm_ext < SUB_W) ? '0 : pm_out - SUB_W[PM_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pm_out    <= INIT_PM;
      dec_bit   <= 1'b0;
      dec_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      dec_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state  <= RUN;
            pm_out <= INIT_PM;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          if (frame_start) begin
            pm_out <= INIT_PM;
          end else if (step_valid) begin
            pm_out    <= acs_pm;
            dec_bit   <= sel;
            dec_valid <= 1'b1;
          end else if (norm_en) begin
            pm_out <= norm_pm;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign norm_req = pm_out[PM_W-1];

endmodule

// File: tb/tb_acs_unit.sv
// Testbench for acs_unit: directed vector table, hand sequences, and randomized
// stimulus compared against a behavioural model, on STATE_ID=5 and STATE_ID=0 nodes.
module tb_acs_unit;

  logic       clk = 1'b0;
  logic       rst, frame_start, step_valid, norm_en;
  logic [7:0] pm_in_0, pm_in_1;
  logic [1:0] bm_0, bm_1;
  logic [7:0] pm5, pm0;
  logic       db5, dv5, nr5, busy5, db0, dv0, nr0, busy0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acs_unit #(.PM_W(8), .STATE_ID(5), .INIT_MAX(63), .NORM_SUB(128)) dut5 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .step_valid(step_valid),
    .pm_in_0(pm_in_0), .pm_in_1(pm_in_1), .bm_0(bm_0), .bm_1(bm_1), .norm_en(norm_en),
    .pm_out(pm5), .dec_bit(db5), .dec_valid(dv5), .norm_req(nr5), .busy(busy5));

  acs_unit #(.PM_W(8), .STATE_ID(0), .INIT_MAX(63), .NORM_SUB(128)) dut0 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .step_valid(step_valid),
    .pm_in_0(pm_in_0), .pm_in_1(pm_in_1), .bm_0(bm_0), .bm_1(bm_1), .norm_en(norm_en),
    .pm_out(pm0), .dec_bit(db0), .dec_valid(dv0), .norm_req(nr0), .busy(busy0));

  typedef struct {
    int r, fs, sv, ne, a0, b0, a1, b1;
    int e_pm, e_db, e_dv, e_busy;
  } vec_t;

  typedef struct {
    int run, pm, db, dv;
  } m_t;

  vec_t vecs[14];
  m_t   m5, m0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int r, input int fs, input int sv, input int ne,
                       input int a0, input int b0, input int a1, input int b1);
    rst         = (r != 0);
    frame_start = (fs != 0);
    step_valid  = (sv != 0);
    norm_en     = (ne != 0);
    pm_in_0     = 8'(a0);
    bm_0        = 2'(b0);
    pm_in_1     = 8'(a1);
    bm_1        = 2'(b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: one trellis step in plain integer arithmetic.
  function automatic m_t model_next(input m_t m, input int init, input int r, input int fs,
                                    input int sv, input int ne, input int a0, input int b0,
                                    input int a1, input int b1);
    m_t n;
    int p0, p1, w, s;
    n = m;
    n.dv = 0;
    if (r != 0) begin
      n.run = 0; n.pm = init; n.db = 0;
    end else if (m.run == 0) begin
      if (fs != 0) begin n.run = 1; n.pm = init; end
    end else if (fs != 0) begin
      n.pm = init;
    end else if (sv != 0) begin
      p0 = a0 + b0;
      p1 = a1 + b1;
      s  = (p1 < p0) ? 1 : 0;
      w  = (s != 0) ? p1 : p0;
      if (ne != 0) w = (w < 128) ? 0 : w - 128;
      if (w > 255) w = 255;
      n.pm = w; n.db = s; n.dv = 1;
    end else if (ne != 0) begin
      n.pm = (m.pm < 128) ? 0 : m.pm - 128;
    end
    return n;
  endfunction

  initial begin
    //              r fs sv ne  a0  b0  a1  b1  pm  db dv busy
    vecs[0]  = '{1, 0, 0, 0,   0, 0,   0, 0,  63, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0,   0, 0,   0, 0,  63, 0, 0, 1};
    vecs[2]  = '{0, 0, 1, 0,  10, 2,   9, 1,  10, 1, 1, 1};
    vecs[3]  = '{0, 0, 1, 0,  20, 1,  19, 2,  21, 0, 1, 1};
    vecs[4]  = '{0, 0, 1, 0, 150, 0, 160, 0, 150, 0, 1, 1};
    vecs[5]  = '{0, 0, 1, 1, 200, 0, 210, 0,  72, 0, 1, 1};
    vecs[6]  = '{0, 0, 1, 0, 254, 2, 255, 2, 255, 0, 1, 1};
    vecs[7]  = '{0, 0, 0, 1,   0, 0,   0, 0, 127, 0, 0, 1};
    vecs[8]  = '{0, 0, 0, 0,   0, 0,   0, 0, 127, 0, 0, 1};
    vecs[9]  = '{0, 0, 1, 0,   5, 0,   3, 0,   3, 1, 1, 1};
    vecs[10] = '{0, 0, 0, 0,   0, 0,   0, 0,   3, 1, 0, 1};
    vecs[11] = '{0, 0, 0, 1,   0, 0,   0, 0,   0, 1, 0, 1};
    vecs[12] = '{1, 0, 0, 0,   0, 0,   0, 0,  63, 0, 0, 0};
    vecs[13] = '{0, 0, 1, 0,   1, 1,   1, 1,  63, 0, 0, 0};

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].r, vecs[i].fs, vecs[i].sv, vecs[i].ne,
            vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1);
      tick();
      chk($sformatf("vec%0d pm_out", i), int'(pm5), vecs[i].e_pm);
      chk($sformatf("vec%0d dec_bit", i), int'(db5), vecs[i].e_db);
      chk($sformatf("vec%0d dec_valid", i), int'(dv5), vecs[i].e_dv);
      chk($sformatf("vec%0d busy", i), int'(busy5), vecs[i].e_busy);
      chk($sformatf("vec%0d norm_req", i), int'(nr5), (vecs[i].e_pm >= 128) ? 1 : 0);
    end

    // STATE_ID=0: frame_start overrides a same-cycle step, then reset mid-run.
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("s0 start pm_out", int'(pm0), 0);
    chk("s0 start busy", int'(busy0), 1);
    drive(0, 0, 1, 0, 30, 1, 40, 1);
    tick();
    chk("s0 step pm_out", int'(pm0), 31);
    chk("s0 step dec_valid", int'(dv0), 1);
    drive(0, 1, 1, 0, 10, 0, 10, 0);
    tick();
    chk("s0 fs+step pm_out", int'(pm0), 0);
    chk("s0 fs+step dec_valid", int'(dv0), 0);
    chk("s5 fs+step pm_out", int'(pm5), 63);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("s0 rst busy", int'(busy0), 0);
    chk("s5 rst busy", int'(busy5), 0);
    chk("s5 rst pm_out", int'(pm5), 63);

    m5 = '{0, 63, 0, 0};
    m0 = '{0, 0, 0, 0};
    for (int i = 0; i < 3000; i++) begin
      int r, fs, sv, ne, a0, b0, a1, b1;
      r  = (i == 0 || $urandom_range(0, 99) == 0) ? 1 : 0;
      fs = ($urandom_range(0, 15) == 0) ? 1 : 0;
      sv = ($urandom_range(0, 3) != 0) ? 1 : 0;
      ne = ($urandom_range(0, 7) == 0) ? 1 : 0;
      a0 = int'($urandom_range(0, 255));
      a1 = int'($urandom_range(0, 255));
      b0 = int'($urandom_range(0, 2));
      b1 = int'($urandom_range(0, 2));
      drive(r, fs, sv, ne, a0, b0, a1, b1);
      @(posedge clk);
      m5 = model_next(m5, 63, r, fs, sv, ne, a0, b0, a1, b1);
      m0 = model_next(m0, 0, r, fs, sv, ne, a0, b0, a1, b1);
      #1;
      chk("rand s5 pm_out", int'(pm5), m5.pm);
      chk("rand s5 dec_bit", int'(db5), m5.db);
      chk("rand s5 dec_valid", int'(dv5), m5.dv);
      chk("rand s5 busy", int'(busy5), m5.run);
      chk("rand s5 norm_req", int'(nr5), (m5.pm >= 128) ? 1 : 0);
      chk("rand s0 pm_out", int'(pm0), m0.pm);
      chk("rand s0 dec_bit", int'(db0), m0.db);
      chk("rand s0 dec_valid", int'(dv0), m0.dv);
      chk("rand s0 busy", int'(busy0), m0.run);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
